// File: rtl/dfp_pkg.sv
// Shared definitions for the decimal floating-point add path:
// digit counts, digit width and the significand adder state encoding.
package dfp_pkg;

  localparam int SIG_DIGITS = 7;
  localparam int GRS_DIGITS = 3;
  localparam int EXT_DIGITS = SIG_DIGITS + GRS_DIGITS;
  localparam int DIGIT_W    = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    RECOMP = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder: s = a + b + cin with decimal correction.
// Inputs are plain 4-bit nibbles; non-BCD nibbles simply wrap.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] bin_sum;
  logic [4:0] adj_sum;

  // Binary sum, then +6 correction whenever it leaves the 0..9 range
  always_comb begin
    bin_sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    adj_sum = bin_sum + 5'd6;
    if (bin_sum > 5'd9) begin
      s    = adj_sum[3:0];
      cout = 1'b1;
    end else begin
      s    = bin_sum[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/decimal_sig_addsub.sv
// Digit-serial BCD significand adder/subtractor (LSD first, 10 digits).
// Subtraction is A + 9's(B) + 1; a missing final carry means B > A and the
// result is re-complemented serially to return a magnitude.
// Optional build macro: DSA_BCD_CHECK_EN (flags non-BCD operand digits).
module decimal_sig_addsub #(
  parameter int SIG_DIGITS = dfp_pkg::SIG_DIGITS,
  parameter int GRS_DIGITS = dfp_pkg::GRS_DIGITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SIG_DIGITS*4-1:0]   M1_norm,
  input  logic [SIG_DIGITS*4-1:0]   M2_norm,
  input  logic [GRS_DIGITS*4-1:0]   GRS_bits,
  input  logic                      Greater,
  input  logic                      op_sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      res_carry,
  output logic [SIG_DIGITS*4-1:0]   res_sig,
  output logic [GRS_DIGITS*4-1:0]   res_grs,
  output logic                      res_neg,
  output logic                      res_zero,
  output logic                      res_invalid
);
  import dfp_pkg::*;

  localparam int EXT_W = (SIG_DIGITS + GRS_DIGITS) * DIGIT_W;
  localparam int GRS_W = GRS_DIGITS * DIGIT_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIG_DIGITS + GRS_DIGITS - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               op_sub_q;
  logic [EXT_W-1:0]   a_q;
  logic [EXT_W-1:0]   b_q;
  logic [EXT_W-1:0]   res_q;
  logic               res_carry_q;
  logic               res_neg_q;
  logic               res_zero_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic [3:0]         add_a;
  logic [3:0]         add_b;
  logic [3:0]         add_s;
  logic               add_cout;
  logic [EXT_W-1:0]   res_nxt;

  function automatic logic [3:0] nines(input logic [3:0] d);
    return 4'd9 - d;
  endfunction

  // Digit operand select: ADD consumes A/B low digits, RECOMP complements the result digit
  always_comb begin
    add_a = a_q[3:0];
    add_b = op_sub_q ? nines(b_q[3:0]) : b_q[3:0];
    if (state_q == RECOMP) begin
      add_a = nines(res_q[3:0]);
      add_b = 4'd0;
    end
    res_nxt = {add_s, res_q[EXT_W-1:DIGIT_W]};
  end

  bcd_digit_add u_digit (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_cout)
  );

`ifdef DSA_BCD_CHECK_EN
  logic bcd_err_q;
  assign res_invalid = bcd_err_q & out_valid_q;
`else
  assign res_invalid = 1'b0;
`endif

  // Control FSM plus serial datapath: operands and result shift one digit per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      op_sub_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      res_carry_q <= 1'b0;
      res_neg_q   <= 1'b0;
      res_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef DSA_BCD_CHECK_EN
      bcd_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q         <= Greater ? {M1_norm, {GRS_W{1'b0}}} : {M1_norm, GRS_bits};
            b_q         <= Greater ? {M2_norm, GRS_bits} : {M2_norm, {GRS_W{1'b0}}};
            op_sub_q    <= op_sub;
            carry_q     <= op_sub;
            cnt_q       <= '0;
            res_carry_q <= 1'b0;
            res_neg_q   <= 1'b0;
            res_zero_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            state_q     <= ADD;
`ifdef DSA_BCD_CHECK_EN
            bcd_err_q   <= 1'b0;
`endif
          end
        end
        ADD: begin
          res_q   <= res_nxt;
          a_q     <= {4'd0, a_q[EXT_W-1:DIGIT_W]};
          b_q     <= {4'd0, b_q[EXT_W-1:DIGIT_W]};
          carry_q <= add_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
`ifdef DSA_BCD_CHECK_EN
          if (a_q[3:0] > 4'd9 || b_q[3:0] > 4'd9) bcd_err_q <= 1'b1;
`endif
          if (cnt_q == LAST) begin
            if (!op_sub_q || add_cout) begin
              res_carry_q <= op_sub_q ? 1'b0 : add_cout;
              res_zero_q  <= (res_nxt == '0);
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              res_neg_q <= 1'b1;
              cnt_q     <= '0;
              carry_q   <= 1'b1;
              state_q   <= RECOMP;
            end
          end
        end
        RECOMP: begin
          res_q   <= res_nxt;
          carry_q <= add_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            res_zero_q  <= (res_nxt == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res_carry = res_carry_q;
  assign res_sig   = res_q[EXT_W-1:GRS_W];
  assign res_grs   = res_q[GRS_W-1:0];
  assign res_neg   = res_neg_q;
  assign res_zero  = res_zero_q;

endmodule

// File: doc/decimal_sig_addsub.md
Name: decimal_sig_addsub

Overview:
- Digit-serial BCD significand adder/subtractor for the decimal floating-point add path.
- Sits directly downstream of significand alignment and consumes its aligned significands (M1_norm, M2_norm, 7 BCD digits each), its guard/round/sticky digits (GRS_bits, 3 BCD digits) and its Greater select.
- Processes one digit per clock, least-significant digit first, across 10 digits (7 significand + 3 GRS).
- Re-complements when a subtraction goes negative, then hands the unrounded magnitude to the normalize/round stage over a valid/ready handshake.

Parameters:
- SIG_DIGITS, 7, significand BCD digits.
- GRS_DIGITS, 3, guard/round/sticky BCD digits appended below the significand.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept; high only in IDLE.
- M1_norm  in  28  aligned significand 1 (BCD).
- M2_norm  in  28  aligned significand 2 (BCD).
- GRS_bits  in  12  GRS digits of the shifted operand.
- Greater  in  1  1: M2 was shifted; 0: M1 was shifted.
- op_sub  in  1  1: subtract (A - B); 0: add.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- res_carry  out  1  decimal carry-out digit (value 1) above the significand.
- res_sig  out  28  result significand digits (BCD magnitude).
- res_grs  out  12  result GRS digits.
- res_neg  out  1  subtraction result was negative (B > A); magnitude is still returned.
- res_zero  out  1  all 10 result digits are zero.
- res_invalid  out  1  non-BCD input digit detected (see Optional Feature).

Behaviour:
- Operand forming at acceptance:
  - Greater=1: A={M1_norm,12'h000}, B={M2_norm,GRS_bits}.
  - Greater=0: A={M1_norm,GRS_bits}, B={M2_norm,12'h000}.
  - Both are 40-bit values of 10 digits.
- Reset: state=IDLE, out_valid=0, all result registers and the digit counter at 0, in_ready=1.
- Reset mid-operation: abandon the operation and return to IDLE; no partial result is emitted.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch A, B and op_sub; cnt=0; carry=op_sub; go to ADD.
  - ADD: per cycle, digit[cnt] = A[cnt] + (op_sub ? 9-B[cnt] : B[cnt]) + carry, with BCD correction (+6 when the binary sum exceeds 9). Update carry, cnt++. At cnt=9:
    - op_sub=0: res_carry=final carry; go to DONE.
    - op_sub=1 and final carry=1: positive result; res_carry=0; go to DONE.
    - op_sub=1 and final carry=0: negative result; res_neg=1; cnt=0; carry=1; go to RECOMP.
  - RECOMP: per cycle, digit[cnt] = (9-digit[cnt]) + carry (10's complement, digit-serial), cnt++. At cnt=9 go to DONE.
  - DONE: out_valid=1 and all result outputs stable. On out_ready, drop out_valid and go to IDLE.
- res_zero is computed over all 10 result digits and registered on entry to DONE.
- Latency, counted from the accepting edge E0: out_valid high after E10, or after E20 when RECOMP runs.
- Throughput: one operation per 11 cycles plus the handshake (21 with RECOMP). There is no overlap; in_ready=0 outside IDLE.
- Backpressure: DONE holds indefinitely while out_ready=0, with all outputs frozen.
- Equal-operand subtraction gives final carry=1, result 0, res_zero=1, res_neg=0.
- Addition overflow (e.g. 9999999+1): res_carry=1, digits wrap to 0. The downstream normalizer consumes the carry.
- Arithmetic is strictly on 4-bit digits; the carry between digits is 1 bit.

Optional Feature:
- Macro: DSA_BCD_CHECK_EN.
- Defined: during ADD, any A or B digit greater than 9 sets a sticky flag. res_invalid mirrors that flag in DONE. The flag clears on the next acceptance.
- Undefined: no check logic is built; res_invalid is tied to 0.
- The arithmetic result is identical in both builds.

Decomposition:
- Shared package dfp_pkg:
  - SIG_DIGITS, GRS_DIGITS and EXT_DIGITS = SIG_DIGITS + GRS_DIGITS.
  - Digit width 4.
  - State enumeration IDLE/ADD/RECOMP/DONE.
- One natural sub-module: bcd_digit_add.
  - Combinational a[3:0], b[3:0], cin -> s[3:0], cout.
  - Used for both ADD and RECOMP (RECOMP uses b=0 with the complemented digit as a).

Test Plan:
- Add: M1=0x1234567, M2=0x0000001, Greater=1, GRS=0x500, op_sub=0 -> res_sig=0x1234568, res_grs=0x500, res_carry=0, res_neg=0, out_valid after E10.
- Add overflow: M1=0x9999999, M2=0x0000001, GRS=0x000, Greater=1, op_sub=0 -> res_carry=1, res_sig=0x0000000, res_grs=0x000, res_zero=1.
- Subtract positive: M1=0x5000000, M2=0x0000001, Greater=1, GRS=0x500, op_sub=1 -> res_sig=0x4999998, res_grs=0x500, res_neg=0, latency 10.
- Subtract negative: M1=0x0000100, M2=0x0000300, Greater=0, GRS=0x000, op_sub=1 -> res_sig=0x0000200, res_neg=1, out_valid after E20.
- Equal subtract: M1=M2=0x7654321, GRS=0x000, op_sub=1 -> res_sig=0, res_zero=1, res_neg=0.
- Control:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs unchanged, in_ready=0; release -> IDLE next cycle, new operand accepted.
  - Assert rst at cnt=4 of ADD -> out_valid=0, in_ready=1 immediately, no result emitted.
